sfp_mul_pipe: RTL
=================

Name: sfp_mul_pipe

Overview:
Pipelined, multi-lane signed fixed-point multiplier with valid/ready flow control and a built-in resize stage.
- Each lane computes the full-width product x*y, then resizes to the output format.
  - Fraction: truncate or round.
  - Integer: wrap or clip.
- Sits between vector/ray-math producers and consumers in the fp_core datapath; replaces single-cycle combinational multiplies on timing-critical paths.

Parameters:
X_IW, 4, integer bits of x (sign included)
X_QW, 4, fractional bits of x
Y_IW, 4, integer bits of y
Y_QW, 4, fractional bits of y
OUT_IW, 4, integer bits of result
OUT_QW, 4, fractional bits of result
LANES, 1, independent parallel multipliers sharing one handshake
STAGES, 2, pipeline register stages (>=1); latency in cycles
CLIP, 0, integer reduction: 0 = wrap, 1 = saturate to max/min
ROUND, 0, fraction reduction: 0 = truncate (floor), 1 = round half up

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
x_val  in  LANES*(X_IW+X_QW)  packed signed x, lane 0 in LSBs
y_val  in  LANES*(Y_IW+Y_QW)  packed signed y, lane 0 in LSBs
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts result
out_val  out  LANES*(OUT_IW+OUT_QW)  packed signed results
clipping  out  LANES  per-lane clip indicator, qualified by out_valid
busy  out  1  any stage holds a valid beat
clip_count  out  16  clipped-beat counter (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert):
  - all stage valid bits = 0;
  - out_valid = 0, out_val = 0, clipping = 0, busy = 0, clip_count = 0;
  - in_ready = 1 once rst_n is high.
- Transfer rules:
  - input beat accepted when in_valid && in_ready;
  - output beat consumed when out_valid && out_ready.
- Pipeline: STAGES register stages, each with a valid bit.
  - Stage k loads from stage k-1 when stage k is empty or stage k advances (bubble collapsing).
  - Last stage advances when out_ready or when it is empty.
  - in_ready = stage 0 empty, or stage 0 advancing this cycle. in_ready is combinational from out_ready; no other comb paths.
- Latency: exactly STAGES cycles from acceptance to out_valid when out_ready is held high. Throughput 1 beat/cycle.
- Stall:
  - Up to STAGES beats are held with no loss and no reordering.
  - out_val and clipping are stable while out_valid && !out_ready.
- Product width:
  - prod = full signed product, integer width X_IW+Y_IW, fraction width X_QW+Y_QW; no overflow possible.
  - Multiply in stage 0; resize in the final stage. Intermediate stages are retiming registers.
- Fraction reduction, D = X_QW+Y_QW-OUT_QW:
  - D > 0, ROUND=0: arithmetic shift right by D.
  - D > 0, ROUND=1: add 2^(D-1), then shift right by D; widen by 1 bit first so the carry is not lost.
  - D <= 0: left shift with zero fill.
- Integer reduction to OUT_IW+OUT_QW bits:
  - CLIP=0: keep the low bits (two's-complement wrap).
  - CLIP=1: values above max -> max, values below min -> min.
  - clipping[lane] = 1 iff the value did not fit. It is also set in wrap mode (signals wrap occurred).
  - Rounding carry that overflows is treated as overflow.
- Lanes are fully independent arithmetically and share the valid/ready/stage control.
- busy = OR of all stage valid bits.
- rst_n asserted mid-flight: all in-flight beats discarded, outputs return to reset values the same cycle.

Optional Feature:
Macro SFP_MUL_PIPE_STATS_EN.
- Defined: clip_count increments by 1 on each output transfer with any clipping bit set; saturates at 0xFFFF; cleared only by reset.
- Undefined: clip_count tied to 0; no counter logic synthesised.
- Port list identical in both cases.

Test Plan:
- Defaults (Q4.4 all), x=0x18 (1.5), y=0x20 (2.0), out_ready=1 -> out_val=0x30 exactly 2 cycles after acceptance, clipping=0.
- CLIP=1, x=0x70 (7.0), y=0x70 -> out_val=0x7F, clipping=1.
  - Same with CLIP=0 -> out_val=0x10, clipping=1.
  - x=0x80, y=0x80 with CLIP=1 -> 0x7F.
- x=0xF0 (-1.0), y=0x08 (0.5) -> 0xF8. x=0x01, y=0x08 -> 0x00 with ROUND=0, 0x01 with ROUND=1.
- STAGES=2, stream 6 beats, out_ready=0 for 5 cycles after the first out_valid:
  - in_ready drops after 2 beats held;
  - out_val stable while stalled;
  - all 6 results in order, no duplicates after release.
- LANES=4, distinct operands per lane, including one lane clipping -> per-lane results correct, only that lane's clipping bit set. With SFP_MUL_PIPE_STATS_EN, clip_count=1.
- Assert rst_n low with 2 beats in flight -> out_valid=0 and busy=0 immediately. No stale beat emitted after release; the next accepted beat completes in 2 cycles.

Source files
------------

// File: rtl/sfp_mul_pipe.sv
// sfp_mul_pipe: pipelined multi-lane signed fixed-point multiplier with valid/ready and resize.
// Optional clipped-beat counter on clip_count is enabled by defining SFP_MUL_PIPE_STATS_EN.
module sfp_mul_pipe #(
  parameter int X_IW   = 4,
  parameter int X_QW   = 4,
  parameter int Y_IW   = 4,
  parameter int Y_QW   = 4,
  parameter int OUT_IW = 4,
  parameter int OUT_QW = 4,
  parameter int LANES  = 1,
  parameter int STAGES = 2,
  parameter int CLIP   = 0,
  parameter int ROUND  = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LANES*(X_IW+X_QW)-1:0]        x_val,
  input  logic [LANES*(Y_IW+Y_QW)-1:0]        y_val,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LANES*(OUT_IW+OUT_QW)-1:0]    out_val,
  output logic [LANES-1:0]                    clipping,
  output logic                                busy,
  output logic [15:0]                         clip_count
);

  localparam int XW = X_IW + X_QW;
  localparam int YW = Y_IW + Y_QW;
  localparam int OW = OUT_IW + OUT_QW;
  localparam int PW = XW + YW;
  localparam int D  = X_QW + Y_QW - OUT_QW;
  localparam int DS = (D > 0) ? D : 0;
  localparam int SH = (D < 0) ? -D : 0;
  localparam int RS = (D > 0) ? D - 1 : 0;
  localparam int WB = PW + 1 + SH;
  localparam int WW = ((WB > OW) ? WB : OW) + 1;
  localparam int L  = STAGES - 1;

  localparam logic signed [WW-1:0] RND  = (D > 0 && ROUND != 0) ? (WW'(1) << RS) : WW'(0);
  localparam logic [OW-1:0]        MAXV = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0]        MINV = {1'b1, {(OW-1){1'b0}}};

  logic [STAGES-1:0]     vld;
  logic [STAGES-1:0]     ld;
  logic [STAGES-1:0]     src_vld;
  logic                  ld_acc;
  logic [LANES*PW-1:0]   prod_in;
  logic [LANES*PW-1:0]   res_src;
  logic [LANES*OW-1:0]   res_val;
  logic [LANES-1:0]      res_clip;

  // A stage may load when it or any stage downstream of it has room this cycle.
  always_comb begin
    ld     = '0;
    ld_acc = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld_acc = ld_acc || !vld[k];
      ld[k]  = ld_acc;
    end
  end

  always_comb begin
    src_vld    = '0;
    src_vld[0] = in_valid;
    for (int k = 1; k < STAGES; k++) src_vld[k] = vld[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) vld[k] <= src_vld[k];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [XW-1:0]   xs;
    logic signed [YW-1:0]   ys;
    logic signed [PW-1:0]   p;
    logic        [PW-1:0]   src;
    logic signed [WW-1:0]   ext;
    logic signed [WW-1:0]   sum;
    logic signed [WW-1:0]   sc;
    logic        [WW-OW:0]  hi;
    logic                   fits;

    assign xs  = x_val[l*XW +: XW];
    assign ys  = y_val[l*YW +: YW];
    assign p   = PW'(xs) * PW'(ys);
    assign prod_in[l*PW +: PW] = p;

    // Extra headroom bit keeps the rounding carry so it shows up as overflow.
    assign src  = res_src[l*PW +: PW];
    assign ext  = {{(WW-PW){src[PW-1]}}, src};
    assign sum  = ext + RND;
    assign sc   = (sum >>> DS) <<< SH;
    assign hi   = sc[WW-1:OW-1];
    assign fits = (&hi) || !(|hi);

    assign res_clip[l] = !fits;
    assign res_val[l*OW +: OW] = (fits || CLIP == 0) ? sc[OW-1:0] : (sc[WW-1] ? MINV : MAXV);
  end

  if (STAGES > 1) begin : g_mid
    logic [LANES*PW-1:0] pq [STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < STAGES - 1; k++) pq[k] <= '0;
      end else begin
        if (ld[0] && src_vld[0]) pq[0] <= prod_in;
        for (int k = 1; k < STAGES - 1; k++) begin
          if (ld[k] && src_vld[k]) pq[k] <= pq[k-1];
        end
      end
    end

    assign res_src = pq[STAGES-2];
  end else begin : g_one
    assign res_src = prod_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val  <= '0;
      clipping <= '0;
    end else if (ld[L] && src_vld[L]) begin
      out_val  <= res_val;
      clipping <= res_clip;
    end
  end

  assign out_valid = vld[L];
  assign busy      = |vld;
  assign in_ready  = ld[0];

`ifdef SFP_MUL_PIPE_STATS_EN
  logic [15:0] clip_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_cnt <= '0;
    end else if (out_valid && out_ready && (|clipping) && clip_cnt != 16'hFFFF) begin
      clip_cnt <= clip_cnt + 16'd1;
    end
  end

  assign clip_count = clip_cnt;
`else
  assign clip_count = '0;
`endif

endmodule
